// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: FSM states, access size codes,
// requester ownership and the alignment rule applied at grant time.
package mem_access_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int CNT_W = 8;

    // Reserved size or an address not aligned to the access size.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lsb);
        logic f;
        f = 1'b1;
        case (size)
            SZ_WORD: f = (lsb != 2'b00);
            SZ_HALF: f = lsb[0];
            SZ_BYTE: f = 1'b0;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_timeout_counter.sv
// Counts ACCESS cycles; tc is high in the TIMEOUT-th cycle so the FSM can give up
// on the same edge. Cleared by clr_i, holds at terminal count.
module mas_timeout_counter
    import mem_access_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (Reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates fetch vs. data requests and sequences the MAR/MOV/MOC/MDR handshake
// to RAM; data wins ties, returns a one-cycle done (+err) to the granted requester.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              if_done,
    output logic              d_done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mar_load,
    output logic              mdr_load,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_moc,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q;
    owner_t            owner_q;
    logic              fault_q;
    logic              mov_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              if_done_q;
    logic              d_done_q;
    logic              err_q;

    logic tc;
    logic timed_out;
    logic to_done;
    logic done_err;

    mas_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .Reset (Reset),
        .clr_i (state_q == ST_SETUP),
        .en_i  (state_q == ST_ACCESS),
        .tc_o  (tc)
    );

    // A late MOC in the terminal cycle still completes the access normally.
    assign timed_out = (state_q == ST_ACCESS) && !mem_moc && tc;

    always_comb begin
        to_done  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            ST_SETUP:   to_done = fault_q;
            ST_ACCESS:  to_done = (mem_moc && !rw_q) || timed_out;
            ST_CAPTURE: to_done = 1'b1;
            default:    to_done = 1'b0;
        endcase
        done_err = fault_q || timed_out;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_FETCH;
            fault_q   <= 1'b0;
            mov_q     <= 1'b0;
            rw_q      <= 1'b1;
            size_q    <= SZ_WORD;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            if (to_done) begin
                if_done_q <= (owner_q == OWN_FETCH);
                d_done_q  <= (owner_q == OWN_DATA);
                err_q     <= done_err;
            end

            case (state_q)
                ST_IDLE: begin
                    if (d_req) begin
                        owner_q <= OWN_DATA;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        rw_q    <= ~d_we;
                        size_q  <= d_size;
                        fault_q <= access_fault(d_size, d_addr[1:0]);
                        state_q <= ST_SETUP;
                    end else if (if_req) begin
                        owner_q <= OWN_FETCH;
                        addr_q  <= if_addr;
                        rw_q    <= 1'b1;
                        size_q  <= SZ_WORD;
                        fault_q <= access_fault(SZ_WORD, if_addr[1:0]);
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (fault_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        mov_q   <= 1'b1;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_moc) begin
                        mov_q <= 1'b0;
                        if (rw_q) begin
                            rdata_q <= mem_rdata;
                            state_q <= ST_CAPTURE;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else if (tc) begin
                        mov_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_CAPTURE: state_q <= ST_DONE;
                ST_DONE:    state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign mar_load  = (state_q == ST_SETUP) && !fault_q;
    assign mdr_load  = (state_q == ST_CAPTURE);
    assign mem_mov   = mov_q;
    assign mem_rw    = rw_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized scoreboard bench for mem_access_sequencer with a RAM responder model.
module tb_mem_access_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          Reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [1:0]    d_size;
    logic [DW-1:0] d_wdata;
    logic          if_done, d_done, err;
    logic [DW-1:0] rdata;
    logic          mar_load, mdr_load, mem_mov, mem_rw;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_moc;
    logic [DW-1:0] mem_rdata;

    mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .if_done(if_done), .d_done(d_done), .err(err), .rdata(rdata),
        .mar_load(mar_load), .mdr_load(mdr_load),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_moc(mem_moc), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_data;
        bit          err;
        logic [31:0] rdata;
        int          done_cyc;
        int          mov;
        int          mar;
        int          mdr;
    } exp_t;

    typedef struct {
        int          waitc;
        logic [31:0] data;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          rw;
    } plan_t;

    exp_t  sb[$];
    plan_t plans[$];

    int checks = 0;
    int failures = 0;
    int movcnt = 0, marcnt = 0, mdrcnt = 0;
    logic [31:0] model_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    endfunction

    // Reference: one transaction starting in an IDLE cycle t; t advances to the next IDLE.
    task automatic model_txn(input bit is_d, input bit rd, input logic [1:0] sz,
                             input logic [31:0] a, input int w, input logic [31:0] data,
                             inout int t);
        exp_t e;
        bit   bad, tmo;
        int   lat;
        bad = misal(sz, a);
        tmo = !bad && (w < 0);
        if (bad)      lat = 2;
        else if (tmo) lat = TO + 2;
        else          lat = rd ? w + 4 : w + 3;
        if (!bad && !tmo && rd) model_rdata = data;
        e.is_data  = is_d;
        e.err      = bad || tmo;
        e.rdata    = model_rdata;
        e.done_cyc = t + lat;
        e.mov      = bad ? 0 : (tmo ? TO : w + 1);
        e.mar      = bad ? 0 : 1;
        e.mdr      = (!bad && !tmo && rd) ? 1 : 0;
        sb.push_back(e);
        if (!bad) plans.push_back('{waitc: w, data: data, addr: a, size: sz, rw: rd});
        t = t + lat + 1;
    endtask

    task automatic issue(input bit do_d, input bit do_f, input bit we, input logic [1:0] sz,
                         input logic [31:0] da, input logic [31:0] wd, input logic [31:0] fa,
                         input int dw, input logic [31:0] dd, input int fw,
                         input logic [31:0] fd, input bit drop_early);
        int t;
        bit pend_d, pend_f;
        @(negedge clk);
        t = cyc;
        if (do_d) model_txn(1'b1, !we, sz, da, dw, dd, t);
        if (do_f) model_txn(1'b0, 1'b1, 2'b00, fa, fw, fd, t);
        d_req = do_d; d_we = we; d_size = sz; d_addr = da; d_wdata = wd;
        if_req = do_f; if_addr = fa;
        pend_d = do_d; pend_f = do_f;
        for (int i = 0; i < 200 && (pend_d || pend_f); i++) begin
            @(negedge clk);
            if (i == 0 && drop_early) d_req = 1'b0;
            if (d_done) begin pend_d = 0; d_req = 1'b0; end
            if (if_done) begin pend_f = 0; if_req = 1'b0; end
        end
        if (pend_d || pend_f) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=pending required=done (cycle %0d)", cyc);
            d_req = 1'b0; if_req = 1'b0;
        end
    endtask

    // RAM responder and strobe probe; also checks the request presented to RAM.
    initial begin
        int    acc;
        plan_t cur;
        acc = 0;
        mem_moc = 1'b0;
        mem_rdata = '0;
        cur = '{waitc: -1, data: 0, addr: 0, size: 0, rw: 0};
        forever begin
            @(negedge clk);
            if (Reset) begin acc = 0; mem_moc = 1'b0; continue; end
            if (mar_load) marcnt++;
            if (mdr_load) mdrcnt++;
            if (mem_mov) begin
                movcnt++;
                if (acc == 0) begin
                    if (plans.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unplanned_access actual=mem_mov required=idle (cycle %0d)", cyc);
                        cur = '{waitc: -1, data: 0, addr: 0, size: 0, rw: 0};
                    end else begin
                        cur = plans.pop_front();
                        chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
                        chk("mem_size", 64'(mem_size), 64'(cur.size));
                        chk("mem_rw", 64'(mem_rw), 64'(cur.rw));
                    end
                end
                mem_moc = (acc == cur.waitc);
                mem_rdata = mem_moc ? cur.data : $urandom;
                acc++;
            end else begin
                acc = 0;
                mem_moc = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        int   mov_b, mar_b, mdr_b;
        mov_b = 0; mar_b = 0; mdr_b = 0;
        forever begin
            @(negedge clk);
            if (Reset) begin mov_b = movcnt; mar_b = marcnt; mdr_b = mdrcnt; continue; end
            if (if_done || d_done) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=if%0b/d%0b required=none (cycle %0d)",
                             if_done, d_done, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", {63'd0, d_done}, {63'd0, e.is_data});
                    chk("done_both", {63'd0, if_done & d_done}, 64'd0);
                    chk("done_err", {63'd0, err}, {63'd0, e.err});
                    chk("done_rdata", 64'(rdata), 64'(e.rdata));
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    chk("mov_cycles", 64'(movcnt - mov_b), 64'(e.mov));
                    chk("mar_pulses", 64'(marcnt - mar_b), 64'(e.mar));
                    chk("mdr_pulses", 64'(mdrcnt - mdr_b), 64'(e.mdr));
                end
                mov_b = movcnt; mar_b = marcnt; mdr_b = mdrcnt;
            end else if (err) begin
                chk("err_without_done", {63'd0, err}, 64'd0);
            end
        end
    end

    initial begin
        bit          we, dd, ff;
        logic [1:0]  sz;
        logic [31:0] da, fa;
        int          dw, fw;

        Reset = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0; if_addr = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_mov", {63'd0, mem_mov}, 64'd0);
        chk("rst_mem_rw", {63'd0, mem_rw}, 64'd1);
        chk("rst_mar", {63'd0, mar_load}, 64'd0);
        chk("rst_mdr", {63'd0, mdr_load}, 64'd0);
        chk("rst_done", {62'd0, if_done, d_done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_size", 64'(mem_size), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        Reset = 1'b0;

        // Directed cases.
        issue(0, 1, 0, 2'b00, 0, 0, 32'h40, 0, 0, 0, 32'hDEADBEEF, 0);
        issue(1, 1, 1, 2'b00, 32'h100, 32'h12345678, 32'h44, 0, 0, 0, 32'hCAFEF00D, 0);
        issue(1, 0, 0, 2'b00, 32'h200, 0, 0, -1, 0, 0, 0, 0);
        issue(1, 0, 0, 2'b00, 32'h102, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 1, 2'b10, 32'h103, 32'hA5, 0, 5, 0, 0, 0, 0);
        issue(1, 0, 0, 2'b01, 32'h106, 0, 0, TO - 1, 32'h0000BEEF, 0, 0, 0);
        issue(1, 0, 0, 2'b11, 32'h108, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 1, 0, 2'b00, 0, 0, 32'h49, 0, 0, 0, 0, 0);

        // Reset in the middle of an access.
        @(negedge clk);
        plans.push_back('{waitc: -1, data: 0, addr: 32'h300, size: 2'b00, rw: 1'b1});
        d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h300;
        repeat (4) @(negedge clk);
        chk("pre_rst_mov", {63'd0, mem_mov}, 64'd1);
        Reset = 1'b1; d_req = 0;
        @(negedge clk);
        chk("mid_rst_mov", {63'd0, mem_mov}, 64'd0);
        chk("mid_rst_done", {62'd0, if_done, d_done}, 64'd0);
        chk("mid_rst_rdata", 64'(rdata), 64'd0);
        plans.delete();
        model_rdata = '0;
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 1, 0, 2'b00, 0, 0, 32'h80, 2, 0, 0, 32'h13579BDF, 0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            dd = $urandom_range(0, 1);
            ff = dd ? $urandom_range(0, 1) : 1'b1;
            we = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            da = $urandom;
            fa = $urandom;
            if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) fa[1:0] = 2'b00;
            dw = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            fw = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
            issue(dd, ff, we, sz, da, $urandom, fa, dw, $urandom, fw, $urandom,
                  dd && ($urandom_range(0, 4) == 0));
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("plans_drained", 64'(plans.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences every memory transaction of the multicycle CPU.
- Arbitrates between the instruction-fetch requester (PC path) and the data requester (load/store path of the control FSM).
- Drives MAR/MDR load strobes and the RAM handshake (MOV out, MOC in); returns read data and a one-cycle done/error pulse to the winning requester.
- Sits between the control unit/PC and the RAM model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max cycles in ACCESS waiting for MOC before error (1..255)

Ports:
clk  in  1  clock
Reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address (PC value)
d_req  in  1  data request, level, held until d_done
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
if_done  out  1  one-cycle pulse, fetch finished
d_done  out  1  one-cycle pulse, data access finished
err  out  1  one-cycle pulse with done: timeout or misaligned/reserved size
rdata  out  DATA_W  registered read data, valid from done onward until next capture
mar_load  out  1  MAR load strobe
mdr_load  out  1  MDR load strobe
mem_mov  out  1  memory operation valid to RAM
mem_rw  out  1  1 = read, 0 = write
mem_size  out  2  access size to RAM
mem_addr  out  ADDR_W  registered address to RAM
mem_wdata  out  DATA_W  registered write data
mem_moc  in  1  memory operation complete from RAM
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Clocking: clk only; all state and outputs registered except strobes decoded from state.
- Reset (any cycle, including mid-transaction): state IDLE; mem_mov=0, mem_rw=1, mar_load=0, mdr_load=0, if_done=d_done=err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_size=0, owner=fetch. An in-flight access is abandoned; no done pulse.
- States: IDLE, SETUP, ACCESS, CAPTURE, DONE.
- IDLE: if d_req -> grant data (fixed priority over fetch; the data op belongs to the instruction in flight). Else if if_req -> grant fetch. Latch addr/wdata/size/rw/owner; go SETUP. Fetch is always a word read.
- Alignment check at grant: word needs addr[1:0]=00, halfword needs addr[0]=0; reserved size 11 is an error. On error -> DONE with err=1, no MOV, no MAR load.
- SETUP (1 cycle): mar_load=1; go ACCESS.
- ACCESS: mem_mov=1; cycle counter starts at 0.
  - mem_moc=1: read -> CAPTURE; write -> DONE.
  - Counter reaches TIMEOUT without MOC -> DONE with err=1.
  - mem_mov drops on the exit edge.
- CAPTURE (reads only): mdr_load=1; rdata <= mem_rdata sampled in the MOC cycle.
- DONE (1 cycle): owner's done=1 plus err if flagged; return IDLE. A request still asserted in IDLE is a new request.
- Latency, request seen in IDLE at cycle 0, MOC first sampled high at cycle k≥2:
  - read: done at k+2
  - write: done at k+1
  - zero-wait RAM (MOC at cycle 2): read done cycle 4, write done cycle 3.
- MOC outside ACCESS is ignored. Request deassertion mid-transaction is ignored; the transaction completes.
- Back-to-back: minimum 1 IDLE cycle between transactions. Starvation of fetch is acceptable; the control FSM never holds d_req across instructions.

Decomposition:
- Shared package: state encoding constants, size codes (SZ_WORD/SZ_HALF/SZ_BYTE), owner encoding.
- One sub-module: mas_timeout_counter (load/clear, enable, terminal-count flag, TIMEOUT parameter).

Test Plan:
- Fetch read, MOC at cycle 2, mem_rdata=32'hDEADBEEF: mar_load cycle 1, mdr_load cycle 3, if_done and rdata=DEADBEEF at cycle 4, err=0.
- Simultaneous if_req and d_req (store, addr 0x100, wdata 0x12345678): data first, d_done cycle 3; fetch granted in the following IDLE, if_done 4 cycles later.
- MOC held low: mem_mov high for exactly 15 cycles, then d_done=1 with err=1, mem_mov=0 next cycle.
- Misaligned word load at addr 0x102: no mem_mov, no mar_load, d_done and err pulse 2 cycles after request.
- Reset asserted in ACCESS: next cycle mem_mov=0, state IDLE, no done pulse; a subsequent fetch completes normally.
- Byte store at 0x103, MOC after 5 wait cycles: mem_size=10, mem_rw=0; d_done 1 cycle after MOC.
